// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM encoding and default pattern for the sequence detector
package seq_det_pkg;
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_e;
    localparam logic [5:0] DEFAULT_PATTERN = 6'b101001;
endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and registered at-max flag
//   i_clk, i_resetn : clock, async active-low reset
//   inc, clr        : increment request, clear (clear wins)
//   count, at_max   : current count, high while count is all-ones
module sat_counter #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max_q;
    always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            count_q  <= '0;
            at_max_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_max_q <= &count_d;
        end
    end
    assign count  = count_q;
    assign at_max = at_max_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with loadable pattern and saturating match counter
//   i_clk, i_resetn            : clock, async active-low reset
//   i_valid, i_data            : qualified serial input bit
//   i_load, i_pattern          : load new pattern (flushes history, forces FILL)
//   i_clear                    : synchronous clear of the match counter
//   o_pattern_found            : one-cycle pulse after the completing bit
//   o_count, o_count_end       : saturating match count and its all-ones flag
//   o_state                    : 0 = FILL, 1 = ARMED
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = 6,
    parameter int                 CNT_WIDTH   = 6,
    parameter int                 OVERLAP     = 1,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(DEFAULT_PATTERN)
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_valid,
    input  logic                 i_data,
    input  logic                 i_load,
    input  logic [PAT_LEN-1:0]   i_pattern,
    input  logic                 i_clear,
    output logic                 o_pattern_found,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_count_end,
    output logic                 o_state
);
    localparam int FW = $clog2(PAT_LEN);
    state_e             state_q, state_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_LEN-1:0] hist_q, hist_d, hist_sh, pat_q, pat_d;
    logic               found_q, accept, entering, match;
    always_comb begin
        // a bit arriving with a load is dropped so it cannot pollute the fresh history
        accept   = i_valid && !i_load;
        hist_sh  = {hist_q[PAT_LEN-2:0], i_data};
        entering = accept && state_q == FILL && fill_q == FW'(PAT_LEN-1);
        match    = accept && (state_q == ARMED || entering) && hist_sh == pat_q;
        hist_d   = i_load ? '0 : accept ? hist_sh : hist_q;
        pat_d    = i_load ? i_pattern : pat_q;
        state_d  = state_q;
        fill_d   = fill_q;
        if (i_load || (match && OVERLAP == 0)) begin
            state_d = FILL;
            fill_d  = '0;
        end else if (entering) begin
            state_d = ARMED;
        end else if (accept && state_q == FILL) begin
            fill_d = fill_q + 1'b1;
        end
    end
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= FILL;
            fill_q  <= '0;
            hist_q  <= '0;
            pat_q   <= RST_PATTERN;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            found_q <= match;
        end
    end
    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .inc      (match),
        .clr      (i_clear),
        .count    (o_count),
        .at_max   (o_count_end)
    );
    assign o_pattern_found = found_q;
    assign o_state         = state_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven scoreboard bench for three detector configurations
module tb_seq_detector_param;
    logic       i_clk = 1'b0, i_resetn = 1'b0, i_valid = 1'b0, i_data = 1'b0, i_load = 1'b0, i_clear = 1'b0;
    logic [5:0] i_pattern = '0;
    logic       fa, fb, fc, ea, eb, ec, sa, sb, sc;
    logic [5:0] ca, cb;
    logic [1:0] cc;

    always #5 i_clk = ~i_clk;

    seq_detector_param dut_a (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_valid(i_valid), .i_data(i_data), .i_load(i_load),
        .i_pattern(i_pattern), .i_clear(i_clear), .o_pattern_found(fa), .o_count(ca),
        .o_count_end(ea), .o_state(sa));
    seq_detector_param #(.OVERLAP(0)) dut_b (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_valid(i_valid), .i_data(i_data), .i_load(i_load),
        .i_pattern(i_pattern), .i_clear(i_clear), .o_pattern_found(fb), .o_count(cb),
        .o_count_end(eb), .o_state(sb));
    seq_detector_param #(.CNT_WIDTH(2)) dut_c (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_valid(i_valid), .i_data(i_data), .i_load(i_load),
        .i_pattern(i_pattern), .i_clear(i_clear), .o_pattern_found(fc), .o_count(cc),
        .o_count_end(ec), .o_state(sc));

    typedef struct {
        bit       rs, v, d, ld, clr;
        bit [5:0] pat;
        bit       efa;
        int       eca;
        bit       efb;
        int       ecb;
    } vec_t;
    typedef struct {
        int sel;
        int row;
        bit ef;
        int ec;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_chk = 0, n_fail = 0;

    task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0d, expected %0d", nm, row, act, req);
        end
    endtask

    function automatic void add(bit rs, bit v, bit d, bit ld, bit clr, bit [5:0] pat,
                                bit efa, int eca, bit efb, int ecb);
        tbl.push_back('{rs, v, d, ld, clr, pat, efa, eca, efb, ecb});
    endfunction

    function automatic void expect_out(int sel, int row, bit ef, int ec_v);
        sbq.push_back('{sel, row, ef, ec_v});
    endfunction

    task automatic drive(bit v, bit d, bit ld, bit clr, bit [5:0] pat);
        @(negedge i_clk);
        i_valid = v; i_data = d; i_load = ld; i_clear = clr; i_pattern = pat;
    endtask

    task automatic do_reset(int row);
        @(negedge i_clk);
        i_resetn = 1'b0; i_valid = 1'b0; i_load = 1'b0; i_clear = 1'b0;
        #2;
        chk("rst_found_a", row, fa, 0); chk("rst_count_a", row, ca, 0); chk("rst_end_a", row, ea, 0); chk("rst_state_a", row, sa, 0);
        chk("rst_found_b", row, fb, 0); chk("rst_count_b", row, cb, 0); chk("rst_end_b", row, eb, 0); chk("rst_state_b", row, sb, 0);
        chk("rst_found_c", row, fc, 0); chk("rst_count_c", row, cc, 0); chk("rst_end_c", row, ec, 0); chk("rst_state_c", row, sc, 0);
        @(negedge i_clk);
        i_resetn = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic f, en;
        int   c;
        forever begin
            @(posedge i_clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                f  = e.sel == 0 ? fa : e.sel == 1 ? fb : fc;
                en = e.sel == 0 ? ea : e.sel == 1 ? eb : ec;
                c  = e.sel == 0 ? int'(ca) : e.sel == 1 ? int'(cb) : int'(cc);
                chk($sformatf("found_%0d", e.sel), e.row, f, e.ef);
                chk($sformatf("count_%0d", e.sel), e.row, c, e.ec);
                chk($sformatf("count_end_%0d", e.sel), e.row, en, e.ec == (e.sel == 2 ? 3 : 63));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       t;
        logic [5:0] p6 = 6'b101001;
        logic [4:0] p5 = 5'b01001;
        int         nm;
        bit         m, b;
        // overlapping stream: A pulses after bits 6 and 11, B only after bit 6
        add(1,1,1,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 1,1,1,1);
        add(0,1,0,0,0,0, 0,1,0,1); add(0,1,1,0,0,0, 0,1,0,1); add(0,1,0,0,0,0, 0,1,0,1);
        add(0,1,0,0,0,0, 0,1,0,1); add(0,1,1,0,0,0, 1,2,0,1);
        // invalid cycles between bits 3 and 4 are ignored
        add(1,1,1,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 0,0,0,0);
        add(0,0,1,0,0,0, 0,0,0,0); add(0,0,1,0,0,0, 0,0,0,0); add(0,0,0,0,0,0, 0,0,0,0);
        add(0,0,1,0,0,0, 0,0,0,0); add(0,0,1,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 1,1,1,1);
        // pattern load mid-stream: bit on load edge discarded, count kept
        add(1,1,1,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 1,1,1,1);
        add(0,1,1,0,0,0, 0,1,0,1); add(0,1,0,0,0,0, 0,1,0,1); add(0,1,1,0,0,0, 0,1,0,1);
        add(0,1,1,1,0,6'b111000, 0,1,0,1);
        add(0,1,1,0,0,0, 0,1,0,1); add(0,1,1,0,0,0, 0,1,0,1); add(0,1,0,0,0,0, 0,1,0,1);
        add(0,1,0,0,0,0, 0,1,0,1); add(0,1,0,0,0,0, 0,1,0,1);
        add(0,1,1,0,0,0, 0,1,0,1); add(0,1,1,0,0,0, 0,1,0,1); add(0,1,1,0,0,0, 0,1,0,1);
        add(0,1,0,0,0,0, 0,1,0,1); add(0,1,0,0,0,0, 0,1,0,1); add(0,1,0,0,0,0, 1,2,1,2);
        // clear on the match edge wins but still pulses
        add(1,1,1,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,1,0, 1,0,1,0);
        add(0,0,0,0,1,0, 0,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 0,0,0,0); add(0,1,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,1,1,0,0,0, 1,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            if (t.rs) do_reset(i);
            drive(t.v, t.d, t.ld, t.clr, t.pat);
            expect_out(0, i, t.efa, t.eca);
            expect_out(1, i, t.efb, t.ecb);
        end

        // mid-stream reset discards the partial match
        do_reset(500);
        for (int k = 0; k < 6; k++) begin
            drive(1, p6[5-k], 0, 0, 0);
            expect_out(0, 500 + k, k == 5, k == 5 ? 1 : 0);
            expect_out(1, 500 + k, k == 5, k == 5 ? 1 : 0);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1, p6[5-k], 0, 0, 0);
            expect_out(0, 510 + k, 0, 1);
            expect_out(1, 510 + k, 0, 1);
        end
        do_reset(520);
        drive(1, 1, 0, 0, 0);
        expect_out(0, 521, 0, 0);
        expect_out(1, 521, 0, 0);

        // 2-bit counter saturates at 3 after the third of five matches
        do_reset(600);
        nm = 0;
        for (int k = 1; k <= 26; k++) begin
            b = k <= 6 ? p6[6-k] : p5[4-((k-7)%5)];
            m = k >= 6 && (k - 6) % 5 == 0;
            if (m) nm++;
            drive(1, b, 0, 0, 0);
            expect_out(2, 600 + k, m, nm > 3 ? 3 : nm);
        end
        drive(0, 0, 0, 0, 0);
        expect_out(2, 630, 0, 3);
        drive(0, 0, 0, 1, 0);
        expect_out(2, 631, 0, 0);

        @(posedge i_clk);
        #2;
        chk("scoreboard_drain", 999, sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_LEN, default 6: pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_WIDTH, default 6: match-counter width; legal range 1..16.
REQ-003 Parameter OVERLAP, default 1: 1 allows overlapping matches, 0 requires non-overlapping matches.
REQ-004 Parameter RST_PATTERN, default 6'b101001 (PAT_LEN bits): pattern held after reset.
REQ-005 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 i_resetn  input  1  asynchronous, active-low reset.
REQ-007 i_valid  input  1  qualifies i_data; a bit is accepted only on a rising edge with i_valid=1.
REQ-008 i_data  input  1  serial data bit.
REQ-009 i_load  input  1  1 = capture i_pattern into the pattern register.
REQ-010 i_pattern  input  PAT_LEN  new pattern; bit PAT_LEN-1 is compared against the oldest received bit.
REQ-011 i_clear  input  1  synchronous clear of the match counter.
REQ-012 o_pattern_found  output  1  one-cycle match pulse.
REQ-013 o_count  output  CNT_WIDTH  number of matches, saturating.
REQ-014 o_count_end  output  1  high while o_count equals all-ones.
REQ-015 o_state  output  1  0 = FILL, 1 = ARMED, for debug.

Function
REQ-016 Accepted bits shall shift into a PAT_LEN-bit history register, newest bit at bit 0; the register shall not change when i_valid=0.
REQ-017 The FSM shall have two states: FILL (fewer than PAT_LEN bits held) and ARMED (PAT_LEN valid bits held).
REQ-018 A fill counter shall count accepted bits in FILL; the FSM shall enter ARMED on the edge that accepts bit number PAT_LEN.
REQ-019 A match is defined as the next history value equalling the pattern register while the FSM is in ARMED or entering ARMED.
REQ-020 Match latency: o_pattern_found shall be high for exactly the one cycle after the edge that accepts the completing bit.
REQ-021 Back-to-back matches shall produce back-to-back pulses.
REQ-022 Overlap, OVERLAP=1: after a match the FSM shall stay ARMED.
REQ-023 Non-overlap, OVERLAP=0: after a match the FSM shall return to FILL with the fill count at 0, so a new match needs PAT_LEN fresh bits.
REQ-024 On a match, o_count shall increment by 1, saturating at 2^CNT_WIDTH-1 with no wrap-around.
REQ-025 o_count_end shall be registered and track o_count == all-ones.
REQ-026 i_clear=1 shall set o_count to 0 on the next edge; if a match occurs on the same edge, the clear wins (count = 0) and the pulse is still emitted.
REQ-027 i_load=1 shall:
  - load the pattern register;
  - clear the history and fill count;
  - force FILL.
REQ-028 An i_valid bit on an i_load edge shall be discarded and shall cause no match.
REQ-029 i_load shall not affect o_count.

Reset
REQ-030 While i_resetn=0, the block shall immediately hold:
  - history = 0, fill count = 0, state = FILL;
  - pattern = RST_PATTERN;
  - o_pattern_found = 0, o_count = 0, o_count_end = 0.
REQ-031 A reset mid-stream shall discard any partial match; detection shall restart from FILL after reset release.

Structure
REQ-032 A shared package seq_det_pkg shall hold the FSM state encodings (FILL=0, ARMED=1) and the default pattern constant 6'b101001.
REQ-033 The saturating counter with clear shall be a sub-module, sat_counter, parameterised by width, with inputs inc and clr and outputs count and at_max.
REQ-034 No combinational path shall exist from any input to any output.

Verification
REQ-035 Defaults, OVERLAP=1, stream 1,0,1,0,0,1,0,1,0,0,1 with i_valid=1 -> pulses after bit 6 and bit 11; o_count=2.
REQ-036 Same stream with OVERLAP=0 -> a single pulse after bit 6; o_count=1.
REQ-037 Stream 101001 with i_valid=0 inserted between bits 3 and 4 for 5 cycles -> one pulse, one cycle after the edge accepting bit 6.
REQ-038 CNT_WIDTH=2, 5 matches -> o_count=3 and o_count_end=1 after the 3rd match; both stay at these values; then i_clear=1 -> o_count=0, o_count_end=0.
REQ-039 i_load with i_pattern=6'b111000 after bits 1,0,1 of 101001 -> no match from the old pattern; stream 111000 -> one pulse; o_count unchanged by the load.
REQ-040 i_resetn=0 asserted after 5 bits of 101001, released, then a final bit 1 -> no pulse; all outputs 0 during reset.
